// File: rtl/bcd_display_mux_if.sv
// ============================================================================
// Module      : bcd_display_mux_if
// Description : Digit/control inputs and display outputs of bcd_display_mux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bcd_display_mux_if;
  logic [15:0] digits_in;
  logic        blank_lz;
  logic [3:0]  blink_mask;
  logic        blink_tick;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  digit_sel;

  modport master (
    output digits_in,
    output blank_lz,
    output blink_mask,
    output blink_tick,
    input  seg_out,
    input  dp_out,
    input  digit_sel
  );

  modport slave (
    input  digits_in,
    input  blank_lz,
    input  blink_mask,
    input  blink_tick,
    output seg_out,
    output dp_out,
    output digit_sel
  );
endinterface

`default_nettype wire

// File: rtl/bcd_display_mux.sv
// ============================================================================
// Module      : bcd_display_mux
// Description : Four-digit multiplexed 7-segment driver with per-frame
//               snapshot, anti-ghost blanking, blink, leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_display_mux #(
  parameter int REFRESH_DIV  = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  wire logic         clk,
  input  wire logic         reset,
  bcd_display_mux_if.slave  bus
);

  localparam int                CNT_W      = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]  C_BLANK    = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [15:0]      r_snap;
  logic             r_phase;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic [3:0]       r_sel;

  logic             w_slot_last;
  logic             w_frame_end;
  logic             w_lit;
  logic [3:0]       w_digit;
  logic [6:0]       w_decode;
  logic [6:0]       w_seg;
  logic             w_dp;
  logic [3:0]       w_sel;

  assign w_slot_last = (r_cnt == C_CNT_LAST);
  assign w_frame_end = w_slot_last && (r_idx == 2'd3);
  assign w_lit       = (r_cnt >= C_BLANK);
  assign w_digit     = r_snap[{r_idx, 2'b00} +: 4];

  // Non-BCD codes show a dash so a corrupted register is visible on the display.
  always_comb begin
    w_decode = 7'h40;
    case (w_digit)
      4'd0:    w_decode = 7'h3F;
      4'd1:    w_decode = 7'h06;
      4'd2:    w_decode = 7'h5B;
      4'd3:    w_decode = 7'h4F;
      4'd4:    w_decode = 7'h66;
      4'd5:    w_decode = 7'h6D;
      4'd6:    w_decode = 7'h7D;
      4'd7:    w_decode = 7'h07;
      4'd8:    w_decode = 7'h7F;
      4'd9:    w_decode = 7'h6F;
      default: w_decode = 7'h40;
    endcase
  end

  always_comb begin
    w_sel = 4'b0000;
    w_seg = 7'h00;
    w_dp  = 1'b0;
    if (w_lit) begin
      w_sel = 4'b0001 << r_idx;
      w_dp  = (r_idx == 2'd2) && !r_phase;
      if (r_phase && bus.blink_mask[r_idx]) begin
        w_seg = 7'h00;
      end else if ((r_idx == 2'd3) && bus.blank_lz && (w_digit == 4'd0)) begin
        w_seg = 7'h00;
      end else begin
        w_seg = w_decode;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_idx   <= 2'd0;
      r_snap  <= 16'h0000;
      r_phase <= 1'b0;
      r_seg   <= 7'h00;
      r_dp    <= 1'b0;
      r_sel   <= 4'b0000;
    end else begin
      if (w_slot_last) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_frame_end) begin
        r_snap <= bus.digits_in;
      end
      if (bus.blink_tick) begin
        r_phase <= ~r_phase;
      end
      r_seg <= w_seg;
      r_dp  <= w_dp;
      r_sel <= w_sel;
    end
  end

  assign bus.seg_out   = r_seg;
  assign bus.dp_out    = r_dp;
  assign bus.digit_sel = r_sel;

endmodule

`default_nettype wire

// File: tb/tb_bcd_display_mux.sv
// ============================================================================
// Module      : tb_bcd_display_mux
// Description : Scoreboard bench for bcd_display_mux (REFRESH_DIV=4, BLANK=1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_display_mux;

  logic clk;
  logic reset;
  int   cyc;
  int   base;
  int   n_checks;
  int   n_fail;

  typedef struct {
    int         cyc;
    logic [3:0] sel;
    logic [6:0] seg;
    logic       dp;
    string      tag;
  } exp_t;

  exp_t sb[$];

  bcd_display_mux_if bus ();

  bcd_display_mux #(
    .REFRESH_DIV  (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_abs(input int c, input logic [3:0] sel, input logic [6:0] seg,
                          input logic dp, input string tag);
    exp_t e;
    e.cyc = c;
    e.sel = sel;
    e.seg = seg;
    e.dp  = dp;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Cycle k after reset release shows slot ((k-1)/4)%4, count (k-1)%4, frame (k-1)/16.
  task automatic expect_slot(input int f, input int s, input logic [6:0] seg, input logic dp);
    int k0;
    k0 = base + 16 * f + 4 * s + 1;
    push_abs(k0, 4'b0000, 7'h00, 1'b0, $sformatf("f%0d_s%0d_blank", f, s));
    for (int c = 1; c < 4; c++)
      push_abs(k0 + c, 4'b0001 << s, seg, dp, $sformatf("f%0d_s%0d_c%0d", f, s, c));
  endtask

  task automatic expect_frame(input int f, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3, input logic dp2);
    expect_slot(f, 0, s0, 1'b0);
    expect_slot(f, 1, s1, 1'b0);
    expect_slot(f, 2, s2, dp2);
    expect_slot(f, 3, s3, 1'b0);
  endtask

  task automatic wait_k(input int k);
    while (cyc < base + k) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_checks++;
        if (e.cyc != cyc || bus.digit_sel !== e.sel || bus.seg_out !== e.seg
            || bus.dp_out !== e.dp) begin
          n_fail++;
          $display("FAIL %s cyc=%0d: got sel=%b seg=%h dp=%b, expected sel=%b seg=%h dp=%b (cyc %0d)",
                   e.tag, cyc, bus.digit_sel, bus.seg_out, bus.dp_out, e.sel, e.seg, e.dp, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: stimulus did not complete, %0d expectations pending", sb.size());
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    base     = 0;
    reset    = 1'b1;
    bus.digits_in  = 16'h0000;
    bus.blank_lz   = 1'b0;
    bus.blink_mask = 4'b0000;
    bus.blink_tick = 1'b0;
    for (int c = 1; c <= 3; c++)
      push_abs(c, 4'b0000, 7'h00, 1'b0, "reset_hold");

    wait_k(3);
    reset = 1'b0;
    base  = cyc;
    expect_frame(0, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b1);

    wait_k(8);
    bus.digits_in = 16'h1234;
    expect_frame(1, 7'h66, 7'h4F, 7'h5B, 7'h06, 1'b1);

    wait_k(20);
    bus.digits_in = 16'h0905;
    bus.blank_lz  = 1'b1;
    expect_frame(2, 7'h6D, 7'h3F, 7'h6F, 7'h00, 1'b1);

    wait_k(48);
    bus.blank_lz = 1'b0;
    expect_frame(3, 7'h6D, 7'h3F, 7'h6F, 7'h3F, 1'b1);

    wait_k(50);
    bus.digits_in = 16'h00A0;
    expect_frame(4, 7'h3F, 7'h40, 7'h3F, 7'h3F, 1'b1);

    wait_k(70);
    bus.digits_in = 16'h1111;
    expect_frame(5, 7'h06, 7'h06, 7'h06, 7'h06, 1'b1);

    wait_k(80);
    bus.blink_mask = 4'b0011;
    wait_k(95);
    bus.blink_tick = 1'b1;
    wait_k(96);
    bus.blink_tick = 1'b0;
    expect_frame(6, 7'h00, 7'h00, 7'h06, 7'h06, 1'b0);

    wait_k(112);
    bus.blink_tick = 1'b1;
    expect_frame(7, 7'h06, 7'h06, 7'h06, 7'h06, 1'b1);
    expect_slot(8, 0, 7'h06, 1'b0);
    expect_slot(8, 1, 7'h06, 1'b0);
    wait_k(113);
    bus.blink_tick = 1'b0;

    // Leave phase set so the reset has something to clear.
    wait_k(136);
    bus.blink_tick = 1'b1;
    push_abs(base + 137, 4'b0000, 7'h00, 1'b0, "f8_s2_blank");
    push_abs(base + 138, 4'b0100, 7'h06, 1'b0, "f8_s2_phase1");
    wait_k(137);
    bus.blink_tick = 1'b0;

    wait_k(138);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int c = 139; c <= 141; c++)
      push_abs(base + c, 4'b0000, 7'h00, 1'b0, "reset_mid_slot2");

    wait_k(141);
    reset = 1'b0;
    base  = cyc;
    expect_frame(0, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b1);

    wait_k(18);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
